student_coeff_bank_dbuf: RTL and testbench

//  Double-buffered, multi-channel coefficient store for the parallel FIR array. Each of

---
 rtl/student_coeff_bank_dbuf.sv | 232 +++++++++++++++++++++++
 tb/tb_student_coeff_bank_dbuf.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_coeff_bank_dbuf.sv
// Double-buffered multi-channel coefficient store.
// Each filter channel owns an active and a shadow bank. Filters read the active bank
// through per-channel registered read ports. The host rewrites the shadow bank over a
// TL-UL slave port (single outstanding access, always granted), then requests a swap
// that is carried out on the next frame-boundary strobe.
// Bank contents are not reset; the host loads them over TL-UL.

package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;
endpackage

module student_coeff_bank_dbuf #(
    parameter int AddrWidth     = 10,
    parameter int CoeffDataSize = 16,
    parameter int NumChannels   = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  tlul_pkg::tl_h2d_t                           tl_i,
    output tlul_pkg::tl_d2h_t                           tl_o,
    input  logic [NumChannels-1:0]                      rd_en_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]       rd_addr_i,
    output logic [NumChannels-1:0][CoeffDataSize-1:0]   rd_data_o,
    input  logic                                        swap_ok_i,
    output logic                                        active_bank_o,
    output logic                                        swap_pending_o
);

    localparam int CW     = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int SramAw = 1 + CW + AddrWidth;
    localparam int Depth  = 2 ** AddrWidth;

    localparam logic [31:0] InfoWord = {8'(NumChannels), 8'(AddrWidth),
                                        8'(CoeffDataSize), 8'h01};

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    // Storage: [channel][bank][index]
    logic [CoeffDataSize-1:0] r_mem [NumChannels][2][Depth];

    swap_state_e r_state;
    logic        r_active;
    logic        r_pending;

    logic [NumChannels-1:0][CoeffDataSize-1:0] r_rd_data;

    logic        r_d_valid;
    logic [2:0]  r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic [31:0] r_d_data;

    logic                     w_a_ready;
    logic                     w_req;
    logic                     w_we;
    logic [SramAw-1:0]        w_word;
    logic                     w_is_ctrl;
    logic [CW-1:0]            w_ch;
    logic [AddrWidth-1:0]     w_idx;
    logic [SramAw-2:0]        w_ctrl_word;
    logic                     w_ch_ok;
    logic                     w_shadow;
    logic [CoeffDataSize-1:0] w_shadow_rd;
    logic [CoeffDataSize-1:0] w_bitmask;
    logic [CoeffDataSize-1:0] w_wdata_merged;
    logic                     w_mem_we;
    logic                     w_swap_wr;
    logic [31:0]              w_rdata;
    logic                     w_unused;

    // Only one access may be outstanding; a new one is taken once the response drains.
    assign w_a_ready   = ~r_d_valid | tl_i.d_ready;
    assign w_req       = tl_i.a_valid & w_a_ready;
    assign w_we        = (tl_i.a_opcode != tlul_pkg::Get);

    assign w_word      = tl_i.a_address[SramAw+1:2];
    assign w_is_ctrl   = w_word[SramAw-1];
    assign w_ch        = w_word[AddrWidth +: CW];
    assign w_idx       = w_word[AddrWidth-1:0];
    assign w_ctrl_word = w_word[SramAw-2:0];
    assign w_ch_ok     = (int'(w_ch) < NumChannels);
    assign w_shadow    = ~r_active;

    assign w_mem_we    = w_req & w_we & ~w_is_ctrl & w_ch_ok;
    assign w_swap_wr   = w_req & w_we & w_is_ctrl &
                         (w_ctrl_word == {(SramAw-1){1'b0}}) & tl_i.a_data[0];

    assign w_unused    = ^{tl_i.a_address, tl_i.a_mask, tl_i.a_data};

    // Host-side view of the shadow bank; absent channels read as zero.
    always_comb begin
        w_shadow_rd = {CoeffDataSize{1'b0}};
        if (w_ch_ok) begin
            w_shadow_rd = r_mem[w_ch][w_shadow][w_idx];
        end else begin
            w_shadow_rd = {CoeffDataSize{1'b0}};
        end
    end

    // Expand byte enables to bit enables; byte lanes past the coefficient width drop out.
    always_comb begin
        w_bitmask = {CoeffDataSize{1'b0}};
        for (int b = 0; b < CoeffDataSize; b++) begin
            w_bitmask[b] = tl_i.a_mask[b/8];
        end
        w_wdata_merged = (w_shadow_rd & ~w_bitmask) |
                         (tl_i.a_data[CoeffDataSize-1:0] & w_bitmask);
    end

    // Read data mux for data space and control space.
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_ctrl) begin
            case (w_ctrl_word)
                (SramAw-1)'(0): w_rdata = {30'h0, r_pending, r_active};
                (SramAw-1)'(1): w_rdata = InfoWord;
                default:        w_rdata = 32'h0;
            endcase
        end else begin
            w_rdata[CoeffDataSize-1:0] = w_shadow_rd;
        end
    end

    // Shadow-bank write port (host side); contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_ch][w_shadow][w_idx] <= w_wdata_merged;
        end
    end

    // Filter read ports: one-cycle latency, hold when not enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_data <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (rd_en_i[c]) begin
                    r_rd_data[c] <= r_mem[c][r_active][rd_addr_i[c]];
                end
            end
        end
    end

    // Swap FSM: a request waits for the next frame-boundary strobe; extra requests are absorbed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_active  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_swap_wr) begin
                        r_state   <= PENDING;
                        r_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (swap_ok_i) begin
                        r_state   <= IDLE;
                        r_pending <= 1'b0;
                        r_active  <= ~r_active;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // TL-UL response register: every accepted access is acknowledged one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= 3'h0;
            r_d_size   <= 2'h0;
            r_d_source <= 8'h0;
            r_d_data   <= 32'h0;
        end else if (w_req) begin
            r_d_valid  <= 1'b1;
            r_d_opcode <= w_we ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_data   <= w_we ? 32'h0 : w_rdata;
        end else if (tl_i.d_ready) begin
            r_d_valid  <= 1'b0;
        end
    end

    assign tl_o.d_valid  = r_d_valid;
    assign tl_o.d_opcode = r_d_opcode;
    assign tl_o.d_size   = r_d_size;
    assign tl_o.d_source = r_d_source;
    assign tl_o.d_data   = r_d_data;
    assign tl_o.d_error  = 1'b0;
    assign tl_o.a_ready  = w_a_ready;

    assign rd_data_o      = r_rd_data;
    assign active_bank_o  = r_active;
    assign swap_pending_o = r_pending;

endmodule

// File: tb/tb_student_coeff_bank_dbuf.sv
// Scoreboard bench for student_coeff_bank_dbuf. A driver issues TL-UL and read-port
// stimulus and pushes the per-cycle expected response into a queue, using a
// behavioural model of banks, swap request and frame strobe. A monitor pops and compares
// on the falling edge.
module tb_student_coeff_bank_dbuf;

    localparam int NC  = 3;
    localparam int AW  = 10;
    localparam int CDS = 16;
    localparam int REG = 8;                 // indices used by the bench per channel
    localparam int CTRL = 32'h1000;         // control space word base (SramAw = 13)
    localparam logic [31:0] CTRL1 = {8'd3, 8'd10, 8'd16, 8'h01};

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    tlul_pkg::tl_h2d_t tl_h2d;
    tlul_pkg::tl_d2h_t tl_d2h;
    logic [NC-1:0]          rd_en;
    logic [NC-1:0][AW-1:0]  rd_addr;
    logic [NC-1:0][CDS-1:0] rd_data;
    logic swap_ok;
    logic active;
    logic pending;

    student_coeff_bank_dbuf #(
        .AddrWidth(AW), .CoeffDataSize(CDS), .NumChannels(NC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_h2d), .tl_o(tl_d2h),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .swap_ok_i(swap_ok), .active_bank_o(active), .swap_pending_o(pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [15:0] m_mem   [NC][2][REG];
    bit          m_known [NC][2][REG];
    bit          m_active;
    bit          m_pending;
    logic [NC-1:0][15:0] m_rd;
    logic [NC-1:0]       m_rdk;

    // tk: 0 no response, 1 write ack, 2 read data checked, 3 read data unknown
    typedef struct packed {
        logic                active;
        logic                pending;
        logic [1:0]          tk;
        logic [31:0]         tdata;
        logic [NC-1:0][15:0] rd;
        logic [NC-1:0]       rdk;
    } rec_t;

    rec_t rec_q[$];
    rec_t mr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw(input int ch, input int idx);
        return (ch << 10) | idx;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied, then clock the DUT.
    task automatic tick();
        rec_t r;
        logic [1:0]  tk = 2'd0;
        logic [31:0] td = 32'h0;
        bit swap_wr = 1'b0;
        bit we;
        int w, ch, idx, cw, sb;
        sb = m_active ? 0 : 1;
        if (tl_h2d.a_valid) begin
            w  = int'(tl_h2d.a_address[14:2]);
            we = (tl_h2d.a_opcode != 3'h4);
            if (w >= CTRL) begin
                cw = w - CTRL;
                if (we) begin
                    tk = 2'd1;
                    if (cw == 0 && tl_h2d.a_data[0]) swap_wr = 1'b1;
                end else begin
                    tk = 2'd2;
                    if (cw == 0)      td = {30'h0, m_pending, m_active};
                    else if (cw == 1) td = CTRL1;
                    else              td = 32'h0;
                end
            end else begin
                ch  = w >> 10;
                idx = w % 1024;
                if (we) begin
                    tk = 2'd1;
                    if (ch < NC) begin
                        for (int k = 0; k < 2; k++)
                            if (tl_h2d.a_mask[k]) m_mem[ch][sb][idx][8*k +: 8] = tl_h2d.a_data[8*k +: 8];
                        if (tl_h2d.a_mask[1:0] == 2'b11) m_known[ch][sb][idx] = 1'b1;
                    end
                end else if (ch >= NC) begin
                    tk = 2'd2;
                    td = 32'h0;
                end else if (m_known[ch][sb][idx]) begin
                    tk = 2'd2;
                    td = {16'h0, m_mem[ch][sb][idx]};
                end else begin
                    tk = 2'd3;
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (rd_en[c]) begin
                m_rd[c]  = m_mem[c][m_active ? 1 : 0][int'(rd_addr[c])];
                m_rdk[c] = m_known[c][m_active ? 1 : 0][int'(rd_addr[c])];
            end
        end
        if (m_pending) begin
            if (swap_ok) begin
                m_pending = 1'b0;
                m_active  = ~m_active;
            end
        end else if (swap_wr) begin
            m_pending = 1'b1;
        end
        r.active = m_active; r.pending = m_pending; r.tk = tk; r.tdata = td;
        r.rd = m_rd; r.rdk = m_rdk;
        @(posedge clk);
        rec_q.push_back(r);
        #1;
        tl_h2d.a_valid = 1'b0;
        rd_en   = '0;
        swap_ok = 1'b0;
    endtask

    task automatic tl_set(input int word, input logic [31:0] data, input logic [3:0] mask, input bit is_read);
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = is_read ? 3'h4 : ((mask == 4'hf) ? 3'h0 : 3'h1);
        tl_h2d.a_address = 32'(word) << 2;
        tl_h2d.a_data    = data;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_source  = 8'($urandom_range(0, 255));
    endtask

    task automatic tl_wr(input int word, input logic [31:0] data, input logic [3:0] mask);
        tl_set(word, data, mask, 1'b0);
        tick();
    endtask

    task automatic tl_rd(input int word);
        tl_set(word, 32'h0, 4'hf, 1'b1);
        tick();
    endtask

    task automatic do_swap();
        tl_wr(CTRL, 32'h1, 4'hf);
        swap_ok = 1'b1;
        tick();
    endtask

    // Monitor: compare one expected record per cycle against the DUT outputs.
    always @(negedge clk) begin
        if (rec_q.size() != 0) begin
            mr = rec_q.pop_front();
            check("active_bank", 32'(active), 32'(mr.active));
            check("swap_pending", 32'(pending), 32'(mr.pending));
            check("d_valid", 32'(tl_d2h.d_valid), 32'(mr.tk != 2'd0));
            if (mr.tk != 2'd0) begin
                check("d_error", 32'(tl_d2h.d_error), 32'h0);
                check("d_opcode", 32'(tl_d2h.d_opcode), (mr.tk == 2'd1) ? 32'h0 : 32'h1);
                if (mr.tk == 2'd2) check("d_data", tl_d2h.d_data, mr.tdata);
            end
            for (int c = 0; c < NC; c++)
                if (mr.rdk[c]) check($sformatf("rd_data[%0d]", c), 32'(rd_data[c]), 32'(mr.rd[c]));
        end
    end

    initial begin
        tl_h2d = '0;
        tl_h2d.d_ready = 1'b1;
        tl_h2d.a_size  = 2'd2;
        rd_en = '0; rd_addr = '0; swap_ok = 1'b0;
        m_active = 1'b0; m_pending = 1'b0; m_rd = '0; m_rdk = '1;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < REG; i++) begin
                    m_mem[c][b][i] = 16'h0; m_known[c][b][i] = 1'b0;
                end
        #16 rst_ni = 1'b1;
        #1;
        // Reset state
        check("rst_active", 32'(active), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_d_valid", 32'(tl_d2h.d_valid), 32'h0);
        for (int c = 0; c < NC; c++) check($sformatf("rst_rd_data[%0d]", c), 32'(rd_data[c]), 32'h0);

        // Control space
        tl_rd(CTRL + 1);
        tl_rd(CTRL);
        tl_wr(CTRL + 2, 32'hffff_ffff, 4'hf);
        tl_rd(CTRL + 2);
        tl_rd(CTRL + 7);

        // Load both banks through the shadow, swapping in between.
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < NC; c++)
                for (int i = 0; i < REG; i++)
                    tl_wr(dw(c, i), $urandom, 4'hf);
            do_swap();
        end
        check("init_active", 32'(active), 32'h0);

        // Shadow write does not disturb the filter view.
        tl_wr(dw(2, 5), 32'h0000_beef, 4'hf);
        tl_rd(dw(2, 5));
        rd_en = 3'b100; rd_addr[2] = 10'd5;
        tick();
        tick();

        // Swap request then frame strobe.
        tl_wr(CTRL, 32'h1, 4'hf);
        check("pending_set", 32'(pending), 32'h1);
        swap_ok = 1'b1; rd_en = 3'b100; rd_addr[2] = 10'd5;
        tick();
        check("swap_active", 32'(active), 32'h1);
        check("swap_cleared", 32'(pending), 32'h0);
        rd_en = 3'b100; rd_addr[2] = 10'd5;
        tick();
        check("new_bank_read", 32'(rd_data[2]), 32'h0000_beef);

        // Request coincident with strobe waits for the next strobe.
        tl_set(CTRL, 32'h1, 4'hf, 1'b0); swap_ok = 1'b1;
        tick();
        check("coinc_no_toggle", 32'(active), 32'h1);
        check("coinc_pending", 32'(pending), 32'h1);
        swap_ok = 1'b1;
        tick();
        check("coinc_toggle", 32'(active), 32'h0);
        tl_wr(CTRL, 32'h1, 4'hf);
        tl_wr(CTRL, 32'h1, 4'hf);
        tl_set(CTRL, 32'h1, 4'hf, 1'b0); swap_ok = 1'b1;
        tick();
        swap_ok = 1'b1;
        tick();
        check("single_toggle", 32'(active), 32'h1);
        check("absorbed_pending", 32'(pending), 32'h0);

        // Byte-masked write and absent channel.
        tl_wr(dw(2, 5), 32'h0000_beef, 4'hf);
        tl_wr(dw(2, 5), 32'hffff_1234, 4'h1);
        tl_rd(dw(2, 5));
        tl_wr(dw(2, 6), 32'h5678_abcd, 4'hc);
        tl_rd(dw(2, 6));
        tl_wr(dw(3, 5), 32'h0000_5555, 4'hf);
        tl_rd(dw(3, 5));
        tl_rd(dw(3, 0));

        // Reset while a swap is pending on bank 1.
        tl_wr(CTRL, 32'h1, 4'hf);
        tl_rd(CTRL);
        #2;
        rst_ni = 1'b0;
        rec_q.delete();
        m_active = 1'b0; m_pending = 1'b0; m_rd = '0; m_rdk = '1;
        #1;
        check("mid_rst_active", 32'(active), 32'h0);
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_d_valid", 32'(tl_d2h.d_valid), 32'h0);
        for (int c = 0; c < NC; c++) check($sformatf("mid_rst_rd[%0d]", c), 32'(rd_data[c]), 32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        tl_rd(CTRL);
        swap_ok = 1'b1;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op == 4 || op == 5)
                tl_set(dw(int'($urandom_range(0, 3)), int'($urandom_range(0, REG-1))), $urandom,
                       4'($urandom_range(0, 15)), 1'b0);
            else if (op == 6 || op == 7)
                tl_set(dw(int'($urandom_range(0, 3)), int'($urandom_range(0, REG-1))), 32'h0, 4'hf, 1'b1);
            else if (op == 8)
                tl_set(CTRL + (($urandom_range(0, 3) == 0) ? 2 : 0), 32'($urandom_range(0, 1)), 4'hf, 1'b0);
            else if (op == 9)
                tl_set(CTRL + int'($urandom_range(0, 3)), 32'h0, 4'hf, 1'b1);
            rd_en = NC'($urandom);
            for (int c = 0; c < NC; c++) rd_addr[c] = AW'($urandom_range(0, REG-1));
            swap_ok = ($urandom_range(0, 3) == 0);
            tick();
        end
        tick();

        for (int i = 0; i < 10 && rec_q.size() != 0; i++) @(negedge clk);
        #1;
        if (rec_q.size() != 0) check("drain", 32'(rec_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
